// File: rtl/str_to_num_pkg.sv
// rtl/str_to_num_pkg.sv - ASCII constants and default width for the decimal string converter
package str_to_num_pkg;

    localparam int W_DEFAULT = 32;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_MINUS = 8'h2D;

endpackage

// File: rtl/str_to_num_acc.sv
// rtl/str_to_num_acc.sv - character classifier and acc*10+digit datapath
// Ports:
//   acc      : current accumulator value
//   ch       : incoming ASCII character
//   is_digit : ch is '0'..'9'
//   is_minus : ch is '-'
//   acc_next : acc*10 + (ch-'0'), modulo 2^W (only meaningful when is_digit)
module str_to_num_acc
    import str_to_num_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] acc,
    input  logic [7:0]   ch,
    output logic         is_digit,
    output logic         is_minus,
    output logic [W-1:0] acc_next
);

    logic [7:0] digit;

    assign is_digit = (ch >= CH_0) && (ch <= CH_9);
    assign is_minus = (ch == CH_MINUS);
    assign digit    = ch - CH_0;

    // Multiply by ten as two shifts and an add; overflow wraps silently.
    assign acc_next = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/str_to_num.sv
// rtl/str_to_num.sv - streaming ASCII decimal to binary converter with valid/ready on both sides
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   s_dtm/s_vld/s_rdy : character input stream
//   n_dtm/n_vld/n_rdy : converted number output stream
module str_to_num
    import str_to_num_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_dtm,
    input  logic         s_vld,
    output logic         s_rdy,
    output logic [W-1:0] n_dtm,
    output logic         n_vld,
    input  logic         n_rdy
);

    logic [W-1:0] acc;
    logic [W-1:0] acc_next;
    logic         have_digit;
    logic         neg;
    logic         is_digit;
    logic         is_minus;
    logic         in_beat;
    logic         out_beat;

    str_to_num_acc #(.W(W)) u_acc (
        .acc      (acc),
        .ch       (s_dtm),
        .is_digit (is_digit),
        .is_minus (is_minus),
        .acc_next (acc_next)
    );

    // Input stalls only while an unread result occupies the output register.
    assign s_rdy    = !rst && (!n_vld || n_rdy);
    assign in_beat  = s_vld && s_rdy;
    assign out_beat = n_vld && n_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            have_digit <= 1'b0;
            neg        <= 1'b0;
            n_vld      <= 1'b0;
            n_dtm      <= '0;
        end else begin
            if (out_beat) begin
                n_vld <= 1'b0;
            end
            if (in_beat) begin
                if (is_digit) begin
                    acc        <= acc_next;
                    have_digit <= 1'b1;
                end else if (is_minus && !have_digit) begin
                    neg <= 1'b1;
                end else begin
                    // Delimiter: emit only if a digit run is open. A result
                    // issued here overrides the clear above so back-to-back
                    // results keep n_vld high without a bubble.
                    if (have_digit) begin
                        n_dtm <= neg ? -acc : acc;
                        n_vld <= 1'b1;
                    end
                    acc        <= '0;
                    have_digit <= 1'b0;
                    neg        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_str_to_num.sv
// tb/tb_str_to_num.sv - scoreboard testbench for str_to_num
module tb_str_to_num;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_dtm = 8'h00;
    logic        s_vld = 1'b0;
    logic        s_rdy;
    logic [31:0] n_dtm;
    logic        n_vld;
    logic        n_rdy = 1'b0;

    always #5 clk = ~clk;

    str_to_num #(.W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_dtm (s_dtm),
        .s_vld (s_vld),
        .s_rdy (s_rdy),
        .n_dtm (n_dtm),
        .n_vld (n_vld),
        .n_rdy (n_rdy)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           beats = 0;
    logic [31:0]  exp_q[$];
    byte unsigned tok[$];
    logic         m_neg = 1'b0;
    logic         pend_lat = 1'b0;
    logic         rst_at_edge = 1'b0;
    logic         started = 1'b0;
    logic         prev_hold = 1'b0;
    logic [31:0]  prev_dtm = 32'h0;
    logic         rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a token is the decimal string of digits; its value is the
    // arithmetic number reduced mod 2^32, negated when a sign preceded it.
    task automatic model_accept(input byte unsigned c);
        longint unsigned v;
        logic [31:0]     r;
        if (c >= 8'h30 && c <= 8'h39) begin
            tok.push_back(c - 8'h30);
        end else if (c == 8'h2D && tok.size() == 0) begin
            m_neg = 1'b1;
        end else begin
            if (tok.size() > 0) begin
                v = 0;
                foreach (tok[i]) v = v * 10 + longint'(tok[i]);
                r = v[31:0];
                if (m_neg) r = 32'd0 - r;
                exp_q.push_back(r);
                pend_lat = 1'b1;
            end
            tok.delete();
            m_neg = 1'b0;
        end
    endtask

    task automatic send_byte(input byte unsigned c);
        int   waited;
        logic took;
        waited = 0;
        took   = 1'b0;
        s_dtm  = c;
        s_vld  = 1'b1;
        while (!took && waited < 200) begin
            @(negedge clk);
            took = s_rdy;
            @(posedge clk);
            waited++;
        end
        if (took) begin
            model_accept(c);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h not accepted, expected accept within 200 cycles", c);
        end
        #1 s_vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rand_rdy = 1'b0;
        n_rdy    = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        tok.delete();
        m_neg    = 1'b0;
        pend_lat = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(posedge clk) begin
        rst_at_edge <= rst;
        started     <= 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) n_rdy = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every cycle checks s_rdy, hold stability, result latency,
    // and pops the scoreboard on each output beat.
    always @(negedge clk) begin
        if (started) begin
            chk("s_rdy", {31'b0, s_rdy}, {31'b0, (!rst && (!n_vld || n_rdy))});
            if (rst_at_edge) begin
                chk("n_vld_reset", {31'b0, n_vld}, 32'd0);
                prev_hold = 1'b0;
                pend_lat  = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_vld", {31'b0, n_vld}, 32'd1);
                    chk("hold_dtm", n_dtm, prev_dtm);
                end
                if (pend_lat) begin
                    chk("latency", {31'b0, n_vld}, 32'd1);
                    pend_lat = 1'b0;
                end
                if (n_vld && n_rdy) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %h expected no beat", n_dtm);
                    end else begin
                        chk("n_dtm", n_dtm, exp_q.pop_front());
                    end
                end
                prev_hold = n_vld && !n_rdy;
                prev_dtm  = n_dtm;
            end
        end
    end

    initial begin
        int          b0;
        int          w;
        int          r;
        byte unsigned c;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s_rdy_after_reset", {31'b0, s_rdy}, 32'd1);
        chk("n_vld_after_reset", {31'b0, n_vld}, 32'd0);
        @(posedge clk);
        #1 n_rdy = 1'b1;

        send_str("123\n");
        repeat (3) @(posedge clk);
        #1;
        send_str("-42 ");
        repeat (3) @(posedge clk);
        #1;
        b0 = beats;
        send_str("  ,-\n");
        repeat (4) @(posedge clk);
        chk("no_output_beats", beats, b0);
        #1;
        send_str("4294967297 ");
        repeat (3) @(posedge clk);

        #1 n_rdy = 1'b0;
        send_str("7 ");
        repeat (3) @(negedge clk);
        chk("bp_s_rdy", {31'b0, s_rdy}, 32'd0);
        chk("bp_n_vld", {31'b0, n_vld}, 32'd1);
        chk("bp_n_dtm", n_dtm, 32'd7);
        @(posedge clk);
        #1 n_rdy = 1'b1;
        send_str("8 ");
        repeat (3) @(posedge clk);
        #1;

        b0 = beats;
        send_str("1 2 3 ");
        repeat (3) @(posedge clk);
        chk("three_beats", beats - b0, 32'd3);
        #1;

        // Pending result and partial number are both discarded by reset.
        n_rdy = 1'b0;
        send_str("3 ");
        do_reset();
        n_rdy = 1'b1;
        send_str("12");
        do_reset();
        n_rdy = 1'b1;
        send_str("5 ");
        repeat (3) @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            r = $urandom_range(0, 9);
            if (r <= 5)      c = 8'h30 + 8'($urandom_range(0, 9));
            else if (r == 6) c = 8'h2D;
            else if (r == 7) c = 8'h20;
            else if (r == 8) c = 8'h2C;
            else begin
                case ($urandom_range(0, 3))
                    0:       c = 8'h0A;
                    1:       c = 8'h61;
                    2:       c = 8'h00;
                    default: c = 8'h3A;
                endcase
            end
            if (c >= 8'h30 && c <= 8'h39 && tok.size() >= 12) c = 8'h20;
            send_byte(c);
        end
        send_byte(8'h20);

        @(posedge clk);
        #1;
        rand_rdy = 1'b0;
        n_rdy    = 1'b1;
        w = 0;
        while (exp_q.size() > 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
